itype_imem_loader: RTL and testbench
====================================

// Module: itype_imem_loader
// PURPOSE
//  Host-side program loader for the single-cycle RISC-V I-type core. It accepts instruction field
//  tuples over a valid/ready port and encodes each into a 32-bit OP-IMM word (the encoder matching
//  the core's decoder). Each word is written into instruction memory at consecutive word addresses.
//  It holds the core in reset while loading, then releases the core's active-low rst after a fixed delay.
// PARAMETERS
//  ADDR_W        8    instruction-memory word-address width
//  MAX_WORDS     256  words per load session (<= 2**ADDR_W)
//  RELEASE_DLY   4    cycles between final write and core reset release (>=1)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       asynchronous, active-low reset
//  start         in   1       begin/restart a load session
//  req_valid     in   1       field tuple valid
//  req_ready     out  1       loader can accept a tuple
//  req_funct3    in   3       funct3 field
//  req_rd        in   5       destination register
//  req_rs1       in   5       source register
//  req_imm       in   12      immediate, raw bits imm[11:0]
//  req_last      in   1       tuple is final word of program
//  imem_we       out  1       instruction-memory write strobe
//  imem_addr     out  ADDR_W  write word address
//  imem_wdata    out  32      encoded instruction
//  core_rst_n    out  1       drives core rst (0 = core held in reset)
//  busy          out  1       state is LOAD or WAIT
//  done          out  1       state is RUN
//  word_count    out  ADDR_W+1  words written this session
//  err_illegal   out  1       sticky: illegal shift encoding replaced by NOP
//  err_trunc     out  1       sticky: session ended at MAX_WORDS without req_last
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE.
//    - All outputs 0, including core_rst_n=0.
//    - Address pointer, word_count, delay counter and both sticky errors cleared.
//  - Encoding: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
//    - funct3=001: imm[11:5] must be 7'h00.
//    - funct3=101: imm[11:5] must be 7'h00 or 7'h20.
//    - On violation: word = 32'h0000_0013 (NOP) and err_illegal is set.
//  - Write latency: a tuple accepted (req_valid & req_ready) in cycle N is written in cycle N+1.
//    - In cycle N+1: imem_we=1 with the captured addr/data.
//    - The pointer and word_count increment at the end of cycle N+1.
//    - imem_we=0 otherwise.
//  - FSM:
//    - IDLE: req_ready=0, core_rst_n=0. start -> LOAD (pointer and count cleared).
//    - LOAD: req_ready=1 unless the accepted-word count has reached MAX_WORDS.
//      Accepting a tuple with req_last=1, or the MAX_WORDS-th tuple, goes to WAIT;
//      in the second case err_trunc is set if req_last=0. req_ready is 0 from the next cycle.
//    - WAIT: the final write completes in the first WAIT cycle.
//      Then count RELEASE_DLY cycles -> RUN. start -> LOAD (restart).
//    - RUN: core_rst_n=1, done=1, req_ready=0. start -> LOAD.
//      core_rst_n=0 from the next cycle; pointer, count and errors are cleared.
//  - start in LOAD restarts the session: pointer and count are cleared.
//    A write already captured in the previous cycle still issues with its captured address.
//  - Simultaneous start and tuple acceptance: start wins and the tuple is not accepted.
//    req_ready is 0 combinationally while start=1.
//  - The pointer never wraps; MAX_WORDS bounds it.
//  - core_rst_n is a registered output (glitch-free).
// TESTING
//  - Reset mid-LOAD after 3 writes -> all outputs 0 immediately, core_rst_n=0.
//    Next start restarts at addr 0, err flags 0.
//  - start; tuples ADDI x1,x0,5 / ADDI x2,x1,-1 (imm 12'hFFF) / SRAI x3,x2,4 (f3=5, imm 12'h404, last)
//    -> writes 0x00500093 @0, 0xFFF08113 @1, 0x40415193 @2; word_count=3.
//    core_rst_n rises 1+RELEASE_DLY cycles after the last write.
//  - SLLI with imm 12'h040 -> NOP 0x00000013 written, err_illegal=1.
//    err_illegal stays 1 through later legal words.
//  - MAX_WORDS=4, 5 tuples offered with no last -> 4 writes @0..3, req_ready=0 afterward.
//    err_trunc=1; core released.
//  - req_valid held with random gaps/back-pressure -> one write per accepted tuple.
//    Addresses are contiguous, with no duplicates or drops.
//  - start asserted in RUN -> core_rst_n=0 next cycle; new session reloads from addr 0.

Source files
------------

// File: rtl/itype_imem_loader_if.sv
// Host-to-loader tuple channel and loader-to-instruction-memory write port.
interface itype_imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [11:0]       req_imm;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_funct3, req_rd, req_rs1, req_imm, req_last,
        input  req_ready,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_funct3, req_rd, req_rs1, req_imm, req_last,
        output req_ready,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/itype_imem_loader.sv
// Program loader for the I-type core: encodes OP-IMM field tuples into instruction memory
// at consecutive word addresses, holding the core in reset until the load has settled.
module itype_imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS   = 256,
    parameter int RELEASE_DLY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    itype_imem_loader_if.slave  bus,
    output logic                core_rst_n,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     word_count,
    output logic                err_illegal,
    output logic                err_trunc
);
    localparam int DLY_W = (RELEASE_DLY < 2) ? 1 : $clog2(RELEASE_DLY + 1);
    localparam logic [ADDR_W:0]  MAX_CNT  = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RELEASE_DLY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W:0]   acc_cnt;
    logic [DLY_W-1:0]  dly;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       data_p1;
    logic              accept;
    logic              last_word;

    // Only SLLI/SRLI/SRAI constrain imm[11:5]; everything else is a plain 12-bit immediate.
    function automatic logic shift_illegal(input logic [2:0] f3, input logic [11:0] imm);
        return ((f3 == 3'b001) && (imm[11:5] != 7'h00)) ||
               ((f3 == 3'b101) && (imm[11:5] != 7'h00) && (imm[11:5] != 7'h20));
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        if (shift_illegal(f3, imm))
            return 32'h0000_0013;
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // start pre-empts acceptance so a restart never swallows a tuple.
    assign bus.req_ready = (state == LOAD) && (acc_cnt < MAX_CNT) && !start;
    assign accept        = bus.req_valid && bus.req_ready;
    assign last_word     = bus.req_last || ((acc_cnt + CNT_ONE) == MAX_CNT);

    assign bus.imem_we    = vld_p1;
    assign bus.imem_addr  = addr_p1;
    assign bus.imem_wdata = data_p1;

    // p1: accepted tuple becomes a memory write one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                addr_p1 <= acc_cnt[ADDR_W-1:0];
                data_p1 <= encode(bus.req_funct3, bus.req_rd, bus.req_rs1, bus.req_imm);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc_cnt     <= '0;
            word_count  <= '0;
            dly         <= '0;
            core_rst_n  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_trunc   <= 1'b0;
        end else if (start) begin
            state      <= LOAD;
            acc_cnt    <= '0;
            word_count <= '0;
            dly        <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            if (state == RUN) begin
                err_illegal <= 1'b0;
                err_trunc   <= 1'b0;
            end
        end else begin
            if (vld_p1)
                word_count <= word_count + CNT_ONE;
            case (state)
                LOAD: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_ONE;
                        if (shift_illegal(bus.req_funct3, bus.req_imm))
                            err_illegal <= 1'b1;
                        if (last_word) begin
                            state <= WAIT;
                            dly   <= '0;
                            if (!bus.req_last)
                                err_trunc <= 1'b1;
                        end
                    end
                end
                // First WAIT cycle carries the final write; release follows RELEASE_DLY later.
                WAIT: begin
                    if (dly == DLY_LAST) begin
                        state      <= RUN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else begin
                        dly <= dly + DLY_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_itype_imem_loader.sv
// Randomized bench for itype_imem_loader with a timestamp-based behavioural model.
module tb_itype_imem_loader;
    localparam int AW   = 3;
    localparam int MAXW = 4;
    localparam int RD   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          core_rst_n, busy, done, err_illegal, err_trunc;
    logic [AW:0]   word_count;

    itype_imem_loader_if #(.ADDR_W(AW)) bus ();

    itype_imem_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW), .RELEASE_DLY(RD)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .core_rst_n(core_rst_n), .busy(busy), .done(done),
        .word_count(word_count), .err_illegal(err_illegal), .err_trunc(err_trunc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoding from field weights rather than bit concatenation.
    function automatic bit m_illegal(input int f3, input int imm);
        int hi;
        hi = imm / 32;
        return (f3 == 1 && hi != 0) || (f3 == 5 && hi != 0 && hi != 32);
    endfunction

    function automatic logic [31:0] m_word(input int f3, input int rd, input int rs1, input int imm);
        if (m_illegal(f3, imm)) return 32'h13;
        return 32'(imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 19);
    endfunction

    bit          m_load, m_wait, m_run, m_pend, m_ill, m_tr;
    int          m_acc, m_wc, m_rel, m_paddr;
    logic [31:0] m_pdata;

    int          wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          wlog_cyc[$];
    int          rise_cyc = -1;
    bit          prev_crn = 1'b0;

    always @(negedge clk) begin : cmp
        bit e_rdy;
        bit take;
        if (!rst) begin
            m_load = 0; m_wait = 0; m_run = 0; m_pend = 0; m_ill = 0; m_tr = 0;
            m_acc = 0; m_wc = 0;
            chk("rst_ready", 32'(bus.req_ready), 0);
            chk("rst_we", 32'(bus.imem_we), 0);
            chk("rst_addr", 32'(bus.imem_addr), 0);
            chk("rst_wdata", bus.imem_wdata, 0);
            chk("rst_core_rst_n", 32'(core_rst_n), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_word_count", 32'(word_count), 0);
            chk("rst_err_illegal", 32'(err_illegal), 0);
            chk("rst_err_trunc", 32'(err_trunc), 0);
        end else begin
            if (m_wait && cyc >= m_rel) begin
                m_wait = 0;
                m_run  = 1;
            end
            e_rdy = m_load && (m_acc < MAXW) && !start;
            chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("imem_we", 32'(bus.imem_we), 32'(m_pend));
            if (m_pend) begin
                chk("imem_addr", 32'(bus.imem_addr), 32'(m_paddr));
                chk("imem_wdata", bus.imem_wdata, m_pdata);
            end
            chk("core_rst_n", 32'(core_rst_n), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_load || m_wait));
            chk("done", 32'(done), 32'(m_run));
            chk("word_count", 32'(word_count), 32'(m_wc));
            chk("err_illegal", 32'(err_illegal), 32'(m_ill));
            chk("err_trunc", 32'(err_trunc), 32'(m_tr));

            take = (bus.req_valid === 1'b1) && e_rdy;
            if (start) begin
                if (m_run) begin m_ill = 0; m_tr = 0; end
                m_load = 1; m_wait = 0; m_run = 0; m_acc = 0; m_wc = 0;
            end else if (m_pend) begin
                m_wc++;
            end
            m_pend = take;
            if (take) begin
                m_paddr = m_acc;
                m_pdata = m_word(int'(bus.req_funct3), int'(bus.req_rd),
                                 int'(bus.req_rs1), int'(bus.req_imm));
                if (m_illegal(int'(bus.req_funct3), int'(bus.req_imm))) m_ill = 1;
                m_acc++;
                if (bus.req_last || m_acc == MAXW) begin
                    m_load = 0;
                    m_wait = 1;
                    m_rel  = cyc + 2 + RD;
                    if (!bus.req_last) m_tr = 1;
                end
            end
        end
        if (bus.imem_we === 1'b1) begin
            wlog_addr.push_back(int'(bus.imem_addr));
            wlog_data.push_back(bus.imem_wdata);
            wlog_cyc.push_back(cyc);
        end
        if (core_rst_n === 1'b1 && !prev_crn) rise_cyc = cyc;
        prev_crn = (core_rst_n === 1'b1);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        rise_cyc = -1;
    endtask

    task automatic send(input int f3, input int rd, input int rs1, input int imm,
                        input bit last, input bit may_restart, output bit restarted);
        bit got;
        got = 0;
        restarted = 0;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'(f3);
        bus.req_rd     = 5'(rd);
        bus.req_rs1    = 5'(rs1);
        bus.req_imm    = 12'(imm);
        bus.req_last   = last;
        for (int i = 0; i < 40 && !got; i++) begin
            start = may_restart && ($urandom_range(0, 11) == 0);
            if (start) restarted = 1;
            @(negedge clk);
            got = (bus.req_ready === 1'b1);
            tick();
            start = 1'b0;
        end
        bus.req_valid = 1'b0;
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout: tuple not accepted within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (done === 1'b1);
        end
        tick();
        chk(name, 32'(ok), 1);
    endtask

    initial begin
        int f3, rd, rs1, imm, len, nacc;
        bit r, any_restart, lastf;
        logic [31:0] prog_exp [3];
        prog_exp = '{32'h00500093, 32'hFFF08113, 32'h40415193};

        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_rd = '0;
        bus.req_rs1 = '0; bus.req_imm = '0; bus.req_last = 1'b0;
        #1 rst = 1'b0;
        idle_n(3);

        chk("model_addi", m_word(0, 1, 0, 5), 32'h00500093);
        chk("model_addi_neg", m_word(0, 2, 1, 'hFFF), 32'hFFF08113);
        chk("model_srai", m_word(5, 3, 2, 'h404), 32'h40415193);
        chk("model_slli_bad", m_word(1, 1, 2, 'h040), 32'h00000013);

        rst = 1'b1;
        tick();

        // Reset in the middle of a load after three writes
        pulse_start();
        for (int i = 0; i < 3; i++) send(0, i + 1, 0, i, 0, 0, r);
        tick();
        chk("pre_rst_word_count", 32'(word_count), 3);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_rst_n", 32'(core_rst_n), 0);
        chk("midrst_word_count", 32'(word_count), 0);
        chk("midrst_busy", 32'(busy), 0);
        tick();
        rst = 1'b1;
        tick();

        // Three-instruction program
        clear_log();
        pulse_start();
        send(0, 1, 0, 5, 0, 0, r);
        send(0, 2, 1, 'hFFF, 0, 0, r);
        send(5, 3, 2, 'h404, 1, 0, r);
        wait_done("prog_done");
        chk("prog_nwrites", 32'(wlog_data.size()), 3);
        for (int k = 0; k < 3; k++) begin
            chk("prog_addr", 32'(wlog_addr[k]), 32'(k));
            chk("prog_data", wlog_data[k], prog_exp[k]);
        end
        chk("prog_word_count", 32'(word_count), 3);
        chk("prog_release_latency", 32'(rise_cyc - wlog_cyc[2]), 32'(RD + 1));

        // Restart from RUN, then an illegal SLLI followed by a legal word
        clear_log();
        pulse_start();
        @(negedge clk);
        chk("restart_core_rst_n", 32'(core_rst_n), 0);
        chk("restart_done", 32'(done), 0);
        tick();
        send(1, 1, 2, 'h040, 0, 0, r);
        send(0, 5, 0, 7, 1, 0, r);
        wait_done("illegal_done");
        chk("illegal_addr0", 32'(wlog_addr[0]), 0);
        chk("illegal_nop", wlog_data[0], 32'h00000013);
        chk("illegal_next", wlog_data[1], 32'h00700293);
        chk("illegal_sticky", 32'(err_illegal), 1);

        // MAX_WORDS tuples without last, then one more offered
        clear_log();
        pulse_start();
        chk("trunc_errs_cleared", 32'(err_illegal), 0);
        for (int i = 0; i < MAXW; i++) send(0, i + 1, i, 16 * i, 0, 0, r);
        bus.req_valid = 1'b1;
        bus.req_last  = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.req_ready !== 1'b0) nacc++;
            tick();
        end
        bus.req_valid = 1'b0;
        chk("trunc_blocked", 32'(nacc), 0);
        wait_done("trunc_done");
        chk("trunc_nwrites", 32'(wlog_data.size()), 32'(MAXW));
        for (int k = 0; k < MAXW; k++) chk("trunc_addr", 32'(wlog_addr[k]), 32'(k));
        chk("trunc_err", 32'(err_trunc), 1);
        chk("trunc_released", 32'(core_rst_n), 1);

        // Random sessions with gaps, restarts in LOAD and WAIT
        for (int s = 0; s < 25; s++) begin
            pulse_start();
            len = $urandom_range(1, MAXW);
            any_restart = 0;
            lastf = 1;
            for (int j = 0; j < len; j++) begin
                idle_n($urandom_range(0, 2));
                f3  = $urandom_range(0, 7);
                rd  = $urandom_range(0, 31);
                rs1 = $urandom_range(0, 31);
                imm = $urandom_range(0, 4095);
                if ((f3 == 1 || f3 == 5) && $urandom_range(0, 2) != 0) imm = imm & 'h41F;
                lastf = (j == len - 1) && !(len == MAXW && $urandom_range(0, 1) == 1);
                send(f3, rd, rs1, imm, lastf, j > 0, r);
                any_restart |= r;
            end
            if (any_restart && !lastf) send(0, 7, 7, 1, 1, 0, r);
            if ($urandom_range(0, 5) == 0) begin
                idle_n($urandom_range(0, 2));
                pulse_start();
                send(4, 9, 3, $urandom_range(0, 4095), 1, 0, r);
            end
            wait_done("rnd_done");
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
